// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes shared with the ALU decoder, FSM states and width default.
package muldiv_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHU  = 5'b01010;
  localparam logic [4:0] OP_MULHSU = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one shift-add multiply step or one restoring-divide step on {hi,lo}.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);
  logic [XLEN:0] sum, shl, diff;
  // Divide keeps hi < b, so diff[XLEN] is exactly the borrow of the trial subtract.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shl = {hi, lo[XLEN-1]};
    diff = shl - {1'b0, b};
    next_hi = is_div ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    next_lo = is_div ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV-style multiply/divide with fixed latency and one-edge special cases.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE,
  output logic            DIV_BY_ZERO
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, b, hi_n, lo_n, ma, mb, short_res, fix_res;
  logic [2*XLEN-1:0] prod;
  logic [4:0] op;
  logic neg_q, neg_r, take, valid, is_div, a_neg, b_neg, dz, ovf, short_path;

  muldiv_iter #(.XLEN(XLEN)) iter (
    .is_div(op[2]), .hi(hi), .lo(lo), .b(b), .next_hi(hi_n), .next_lo(lo_n)
  );

  always_comb begin
    take = START && (state == S_IDLE || state == S_DONE);
    valid = SELECT >= OP_MUL && SELECT <= OP_REMU;
    is_div = valid && SELECT[2];
    a_neg = (SELECT inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && DATA1[XLEN-1];
    b_neg = (SELECT inside {OP_MULH, OP_DIV, OP_REM}) && DATA2[XLEN-1];
    ma = a_neg ? -DATA1 : DATA1;
    mb = b_neg ? -DATA2 : DATA2;
    dz = is_div && DATA2 == '0;
    ovf = (SELECT == OP_DIV || SELECT == OP_REM) && DATA1 == MIN_NEG && DATA2 == '1;
    short_path = !valid || dz || ovf;
    short_res = !valid ? '0 : dz ? (SELECT[1] ? DATA1 : '1) : (SELECT[1] ? '0 : DATA1);
    prod = neg_q ? -{hi, lo} : {hi, lo};
    fix_res = !op[2] ? (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
            : op[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo);
  end

  always_comb begin
    state_n = state;
    state_n = FLUSH ? S_IDLE
            : take ? (short_path ? S_DONE : S_CALC)
            : state == S_CALC ? (cnt == CNT_W'(XLEN-1) ? S_FIX : S_CALC)
            : state == S_FIX ? S_DONE
            : state == S_DONE ? S_IDLE : state;
  end

  always_ff @(posedge CLK)
    if (!RESET) state <= S_IDLE;
    else state <= state_n;

  // RESULT and DIV_BY_ZERO only move on the edge that enters DONE.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      b <= '0;
      op <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      RESULT <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else if (take && !FLUSH) begin
      op <= SELECT;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      cnt <= '0;
      hi <= '0;
      lo <= is_div ? ma : mb;
      b <= is_div ? mb : ma;
      if (short_path) begin
        RESULT <= short_res;
        DIV_BY_ZERO <= dz;
      end
    end else if (state == S_CALC) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + CNT_W'(1);
    end else if (state == S_FIX && !FLUSH) begin
      RESULT <= fix_res;
      DIV_BY_ZERO <= 1'b0;
    end
  end

  assign BUSY = state == S_CALC || state == S_FIX;
  assign DONE = state == S_DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus flush/reset/back-to-back sequences for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } vec_t;
  localparam int NV = 26;
  logic CLK, RESET, START, FLUSH, BUSY, DONE, DIV_BY_ZERO;
  logic [4:0] SELECT;
  logic [31:0] DATA1, DATA2, RESULT, prev_res;
  int n_chk, n_bad;
  vec_t tv [NV];

  muldiv_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accept one request, scramble the inputs, then time DONE relative to the accept edge.
  task automatic run(input string nm, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] bb,
                     input logic [31:0] er, input logic ed, input int el);
    int lat;
    logic stable;
    SELECT = sel; DATA1 = a; DATA2 = bb; START = 1'b1;
    tick();
    START = 1'b0; SELECT = 5'($urandom); DATA1 = $urandom; DATA2 = $urandom;
    chk({nm, " busy"}, 32'(BUSY), 32'(el != 0));
    lat = 0;
    stable = 1'b1;
    while (!DONE && lat < 60) begin
      if (RESULT !== prev_res) stable = 1'b0;
      tick();
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " result"}, RESULT, er);
    chk({nm, " dbz"}, 32'(DIV_BY_ZERO), 32'(ed));
    chk({nm, " hold"}, 32'(stable), 32'd1);
    prev_res = er;
    tick();
    chk({nm, " pulse"}, 32'(DONE), 32'd0);
  endtask

  task automatic no_done(input string nm, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (DONE || BUSY) seen = 1'b1;
    end
    chk({nm, " quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    tv[0]  = '{OP_MUL,    32'd25,        32'd20,        32'd500,       1'b0, 33};
    tv[1]  = '{OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 33};
    tv[2]  = '{OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  1'b0, 33};
    tv[3]  = '{OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 33};
    tv[4]  = '{OP_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  1'b0, 33};
    tv[5]  = '{OP_MUL,    32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  1'b0, 33};
    tv[6]  = '{OP_MULH,   32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF,  1'b0, 33};
    tv[7]  = '{OP_MULHSU, 32'd5,         32'hFFFFFFFF,  32'h00000004,  1'b0, 33};
    tv[8]  = '{OP_DIV,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 33};
    tv[9]  = '{OP_REM,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, 33};
    tv[10] = '{OP_REMU,   32'd7,         32'd2,         32'd1,         1'b0, 33};
    tv[11] = '{OP_DIVU,   32'd7,         32'd2,         32'd3,         1'b0, 33};
    tv[12] = '{OP_DIV,    32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0, 33};
    tv[13] = '{OP_REM,    32'd7,         32'hFFFFFFFE,  32'd1,         1'b0, 33};
    tv[14] = '{OP_DIVU,   32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  1'b0, 33};
    tv[15] = '{OP_REMU,   32'hFFFFFFFF,  32'h10,        32'h0000000F,  1'b0, 33};
    tv[16] = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFFFFFF,  1'b1, 0};
    tv[17] = '{OP_REMU,   32'd5,         32'd0,         32'd5,         1'b1, 0};
    tv[18] = '{OP_REM,    32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1, 0};
    tv[19] = '{OP_DIV,    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 0};
    tv[20] = '{5'b10000,  32'd9,         32'd3,         32'd0,         1'b0, 0};
    tv[21] = '{OP_REM,    32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, 0};
    tv[22] = '{OP_DIVU,   32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, 33};
    tv[23] = '{OP_DIV,    32'd5,         32'd0,         32'hFFFFFFFF,  1'b1, 0};
    tv[24] = '{OP_MULHU,  32'h00010000,  32'h00010000,  32'd1,         1'b0, 33};
    tv[25] = '{5'b00111,  32'd9,         32'd3,         32'd0,         1'b0, 0};
    n_chk = 0; n_bad = 0;
    RESET = 1'b0; START = 1'b1; FLUSH = 1'b0; SELECT = OP_DIV; DATA1 = 32'd5; DATA2 = 32'd0;
    repeat (3) tick();
    chk("reset result", RESULT, 32'd0);
    chk("reset busy", 32'(BUSY), 32'd0);
    chk("reset done", 32'(DONE), 32'd0);
    chk("reset dbz", 32'(DIV_BY_ZERO), 32'd0);
    START = 1'b0; RESET = 1'b1; prev_res = 32'd0;
    tick();
    for (int i = 0; i < NV; i++)
      run($sformatf("v%0d", i), tv[i].sel, tv[i].a, tv[i].b, tv[i].res, tv[i].dbz, tv[i].lat);
    // Flush ten cycles into a divide, with START raised alongside to check priority.
    SELECT = OP_DIV; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (10) tick();
    FLUSH = 1'b1; START = 1'b1;
    tick();
    FLUSH = 1'b0; START = 1'b0;
    chk("flush busy", 32'(BUSY), 32'd0);
    chk("flush done", 32'(DONE), 32'd0);
    chk("flush result", RESULT, prev_res);
    no_done("flush", 40);
    run("after flush", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33);
    // Reset mid-op, START held high through the reset edge.
    SELECT = OP_MUL; DATA1 = 32'd7; DATA2 = 32'd9; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    RESET = 1'b0; START = 1'b1;
    tick();
    RESET = 1'b1; START = 1'b0;
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst result", RESULT, 32'd0);
    prev_res = 32'd0;
    no_done("rst", 40);
    run("after rst", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33);
    // START held through a whole op: the second request lands only in the DONE cycle.
    SELECT = OP_MUL; DATA1 = 32'd6; DATA2 = 32'd7; START = 1'b1;
    tick();
    DATA1 = 32'd2; DATA2 = 32'd3;
    lat = 0;
    while (!DONE && lat < 60) begin tick(); lat++; end
    chk("held lat1", 32'(lat), 32'd33);
    chk("held res1", RESULT, 32'd42);
    tick();
    START = 1'b0;
    chk("held busy2", 32'(BUSY), 32'd1);
    chk("held done2", 32'(DONE), 32'd0);
    lat = 0;
    while (!DONE && lat < 60) begin tick(); lat++; end
    chk("held lat2", 32'(lat), 32'd33);
    chk("held res2", RESULT, 32'd6);
    tick();
    chk("held pulse", 32'(DONE), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
